// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and centre-of-bit sampling.
// Optional frame_error strobe when UART_RX_FRAME_ERR_EN is defined.
module uart_rx #(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       data_ready,
  output logic [7:0] data
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       frame_error
`endif
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_HALF = CW'(HALF_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_d;
  logic          rx_meta, rx_s, rx_prev;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shift, shift_d;
  logic [7:0]    data_d;
  logic          ready_d;
`ifdef UART_RX_FRAME_ERR_EN
  logic          ferr_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      data       <= '0;
      data_ready <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_error <= 1'b0;
`endif
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      rx_prev    <= rx_s;
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      shift      <= shift_d;
      data       <= data_d;
      data_ready <= ready_d;
`ifdef UART_RX_FRAME_ERR_EN
      frame_error <= ferr_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CW'(1);
    idx_d   = idx;
    shift_d = shift;
    data_d  = data;
    ready_d = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    ferr_d  = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_d = '0;
        // Edge-triggered start so a held-low line (break) cannot retrigger.
        if (rx_prev && !rx_s) state_d = START;
      end
      START: begin
        if (cnt == LAST_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST_BIT) begin
          cnt_d        = '0;
          shift_d[idx] = rx_s;
          if (idx == 3'd7) state_d = STOP;
          else             idx_d   = idx + 3'd1;
        end
      end
      STOP: begin
        if (cnt == LAST_BIT) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d  = shift;
            ready_d = 1'b1;
          end else begin
`ifdef UART_RX_FRAME_ERR_EN
            ferr_d = 1'b1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 25000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate in bit/s.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-006 data_ready  output  1  single-cycle strobe: a valid byte is on data.
REQ-007 data  output  8  last correctly received byte.
REQ-008 frame_error  output  1  single-cycle strobe: stop bit sampled low (present only with UART_RX_FRAME_ERR_EN).

Function
REQ-009 Bit period CLKS_PER_BIT SHALL be CLK_FREQ/BAUD, integer-truncated (217 at defaults).
REQ-010 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rx_s.
REQ-011 States SHALL be IDLE, START, DATA and STOP; one cycle counter and one 3-bit bit index.
REQ-012 IDLE: a falling edge on rx_s (previous 1, current 0) SHALL enter START with the counter cleared; a constant-low rx_s SHALL NOT start a frame.
REQ-013 START: at counter = CLKS_PER_BIT/2 - 1, if rx_s = 0 the block SHALL enter DATA with the counter cleared; otherwise it SHALL return to IDLE (glitch reject, no strobes).
REQ-014 DATA: every CLKS_PER_BIT cycles the block SHALL sample rx_s into shift-register bit [index], LSB first; after index 7 it SHALL enter STOP.
REQ-015 STOP: after CLKS_PER_BIT cycles it SHALL sample rx_s; if 1, it SHALL load data from the shift register and pulse data_ready for exactly one cycle, starting the cycle after the sample.
REQ-016 A low stop sample SHALL leave data unchanged, SHALL NOT assert data_ready, and SHALL return to IDLE.
REQ-017 After STOP the block SHALL return to IDLE in the same cycle as the strobe, so a start bit immediately following a stop bit is accepted (back-to-back bytes).
REQ-018 data SHALL hold its value between strobes; data_ready SHALL never be high for two consecutive cycles.
REQ-019 Latency from the centre of the stop bit to data_ready SHALL be 1 cycle, plus the 2-cycle synchronizer delay relative to the pin.

Reset
REQ-020 While rst = 1: state = IDLE, counters = 0, shift register = 0, data = 8'h00, data_ready = 0, frame_error = 0, both synchronizer flops = 1.
REQ-021 Reset asserted mid-frame SHALL abort the frame without any strobe; after release, the next full frame SHALL be received normally.

Configuration
REQ-022 Macro UART_RX_FRAME_ERR_EN defined: port frame_error exists and pulses for one cycle in place of data_ready on a low stop sample.
REQ-023 Macro UART_RX_FRAME_ERR_EN undefined: port frame_error is absent; a bad frame is dropped silently; all other behaviour is identical.

Verification
REQ-024 Send 0x41 at 115200 with default parameters -> exactly one data_ready pulse, data = 0x41, no frame_error.
REQ-025 Send 0x41 then 0x0A with no idle gap -> two data_ready pulses, data = 0x41 then 0x0A, strobes spaced 10 bit periods (2170 cycles) apart.
REQ-026 Drive rx low for 50 cycles, then high -> no data_ready, state back to IDLE; a following 0x55 is received correctly.
REQ-027 Send 0x7E with stop bit forced low -> no data_ready, data unchanged; frame_error pulses once when the macro is defined.
REQ-028 Hold rx low for 30 bit periods (break), then release and send 0x31 -> at most one frame_error and no data_ready during the break; data = 0x31 afterwards.
REQ-029 Assert rst during bit 4 of a byte -> no strobe; data = 0x00; the next byte 0xA5 -> data_ready with data = 0xA5.
